hex_word_streamer: RTL and testbench

HEX_WORD_STREAMER -- requirements
Module: hex_word_streamer

---
 rtl/hex_word_streamer_pkg.sv | 20 ++
 rtl/hex_word_streamer_if.sv | 24 ++
 rtl/hex_word_streamer_nibble_to_hex.sv | 14 +
 rtl/hex_word_streamer.sv | 137 +++++++++++++
 tb/tb_hex_word_streamer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_word_streamer_pkg.sv
// Shared FSM encoding and control-character constants for the hex word streamer.
// HEX_STREAM_NEWLINE_EN adds the CR/LF states used for line breaks.
package hex_word_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIGIT = 3'd1,
`ifdef HEX_STREAM_NEWLINE_EN
    ST_SEP   = 3'd2,
    ST_CR    = 3'd3,
    ST_LF    = 3'd4
`else
    ST_SEP   = 3'd2
`endif
  } state_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/hex_word_streamer_if.sv
// Word handshake and serial-transmitter strobe bundle for the hex word streamer.
interface hex_word_streamer_if #(
  parameter int WORD_WIDTH = 16
);
  import hex_word_streamer_pkg::*;

  logic [WORD_WIDTH-1:0] word_i;
  logic                  word_valid_i;
  logic                  word_ready_o;
  logic                  tx_full_i;
  logic                  xmit_o;
  logic [7:0]            txchar_o;
  logic                  busy_o;

  modport slave (
    input  word_i, word_valid_i, tx_full_i,
    output word_ready_o, xmit_o, txchar_o, busy_o
  );

  modport master (
    output word_i, word_valid_i, tx_full_i,
    input  word_ready_o, xmit_o, txchar_o, busy_o
  );
endinterface

// File: rtl/hex_word_streamer_nibble_to_hex.sv
// Maps a 4-bit value to its lowercase ASCII hex digit.
module nibble_to_hex
  import hex_word_streamer_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h57 + {4'h0, nibble};
  end

endmodule

// File: rtl/hex_word_streamer.sv
// Prints accepted words as lowercase hex characters into a serial transmit FIFO.
// Define HEX_STREAM_NEWLINE_EN to end every LINE_WORDS-th word with CR LF instead of SEP_CHAR.
//
// state    | meaning
// IDLE     | ready for a new word
// DIGIT    | emitting hex digits, MSB nibble first
// SEP      | emitting the separator after a word
// CR / LF  | emitting the line break (newline build only)
module hex_word_streamer
  import hex_word_streamer_pkg::*;
#(
  parameter int         WORD_WIDTH = 16,
  parameter int         LINE_WORDS = 8,
  parameter logic [7:0] SEP_CHAR   = 8'h20
) (
  input logic clk,
  input logic nreset,
  hex_word_streamer_if.slave bus
);

  localparam int NIB_W = (WORD_WIDTH > 4) ? $clog2(WORD_WIDTH / 4) : 1;
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(WORD_WIDTH / 4 - 1);

  if (WORD_WIDTH % 4 != 0 || WORD_WIDTH < 4 || WORD_WIDTH > 32 ||
      LINE_WORDS < 2 || LINE_WORDS > 255) begin : g_bad_param
    $error("hex_word_streamer: illegal WORD_WIDTH or LINE_WORDS");
  end

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [NIB_W-1:0]      nib_q, nib_d;
  logic                  xmit_q, emit;
  logic [7:0]            txchar_q, emit_char, hex_char;

  nibble_to_hex u_nibble_to_hex (
    .nibble (shift_q[WORD_WIDTH-1 -: 4]),
    .ascii  (hex_char)
  );

`ifdef HEX_STREAM_NEWLINE_EN
  localparam logic [7:0] LINE_LAST = 8'(LINE_WORDS - 1);
  logic [7:0] line_q, line_d;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    nib_d     = nib_q;
    emit      = 1'b0;
    emit_char = txchar_q;
`ifdef HEX_STREAM_NEWLINE_EN
    line_d    = line_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.word_valid_i) begin
          shift_d = bus.word_i;
          nib_d   = NIB_LAST;
          state_d = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        if (!bus.tx_full_i) begin
          emit      = 1'b1;
          emit_char = hex_char;
          shift_d   = shift_q << 4;
          nib_d     = nib_q - NIB_W'(1);
          if (nib_q == '0) begin
`ifdef HEX_STREAM_NEWLINE_EN
            state_d = (line_q == LINE_LAST) ? ST_CR : ST_SEP;
`else
            state_d = ST_SEP;
`endif
          end
        end
      end
      ST_SEP: begin
        if (!bus.tx_full_i) begin
          emit      = 1'b1;
          emit_char = SEP_CHAR;
          state_d   = ST_IDLE;
`ifdef HEX_STREAM_NEWLINE_EN
          line_d    = line_q + 8'd1;
`endif
        end
      end
`ifdef HEX_STREAM_NEWLINE_EN
      ST_CR: begin
        if (!bus.tx_full_i) begin
          emit      = 1'b1;
          emit_char = CHAR_CR;
          state_d   = ST_LF;
        end
      end
      ST_LF: begin
        if (!bus.tx_full_i) begin
          emit      = 1'b1;
          emit_char = CHAR_LF;
          state_d   = ST_IDLE;
          line_d    = 8'd0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      nib_q    <= '0;
      xmit_q   <= 1'b0;
      txchar_q <= 8'h20;
`ifdef HEX_STREAM_NEWLINE_EN
      line_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      nib_q   <= nib_d;
      xmit_q  <= emit;
      // txchar holds its last value between strobes
      if (emit) txchar_q <= emit_char;
`ifdef HEX_STREAM_NEWLINE_EN
      line_q  <= line_d;
`endif
    end
  end

  assign bus.word_ready_o = (state_q == ST_IDLE) && nreset;
  assign bus.xmit_o       = xmit_q;
  assign bus.txchar_o     = txchar_q;
  // the final strobe lands while already back in IDLE, so it still counts as busy
  assign bus.busy_o       = (state_q != ST_IDLE) || xmit_q;

endmodule

// File: tb/tb_hex_word_streamer.sv
// Directed self-checking bench for hex_word_streamer (16-bit and 8-bit instances).
module tb_hex_word_streamer;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  hex_word_streamer_if #(.WORD_WIDTH(16)) if16 ();
  hex_word_streamer_if #(.WORD_WIDTH(8))  if8 ();

  hex_word_streamer #(.WORD_WIDTH(16), .LINE_WORDS(2), .SEP_CHAR(8'h20)) dut16 (
    .clk(clk), .nreset(nreset), .bus(if16));
  hex_word_streamer #(.WORD_WIDTH(8)) dut8 (
    .clk(clk), .nreset(nreset), .bus(if8));

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [15:0] acc16_w[$];
  int          acc16_c[$];
  int          acc8_c[$];
  logic [7:0]  ch16[$];
  int          ch16_c[$];
  logic        ch16_b[$];
  logic [7:0]  ch8[$];
  int          ch8_c[$];

  always @(posedge clk) begin
    if (nreset && if16.word_valid_i && if16.word_ready_o) begin
      acc16_w.push_back(if16.word_i);
      acc16_c.push_back(cyc);
    end
    if (nreset && if8.word_valid_i && if8.word_ready_o) acc8_c.push_back(cyc);
    cyc = cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    if (if16.xmit_o) begin
      ch16.push_back(if16.txchar_o);
      ch16_c.push_back(cyc);
      ch16_b.push_back(if16.busy_o);
    end
    if (if8.xmit_o) begin
      ch8.push_back(if8.txchar_o);
      ch8_c.push_back(cyc);
    end
  end

  function automatic int str_diff(input logic [7:0] q[$], input string s);
    if (q.size() != s.len()) return -2;
    for (int i = 0; i < s.len(); i++)
      if (q[i] != s[i]) return i;
    return -1;
  endfunction

  function automatic string q2s(input logic [7:0] q[$]);
    string s = "";
    for (int i = 0; i < q.size() && i < 32; i++) s = $sformatf("%s%02h ", s, q[i]);
    return s;
  endfunction

  task automatic clear_logs();
    acc16_w.delete(); acc16_c.delete(); acc8_c.delete();
    ch16.delete(); ch16_c.delete(); ch16_b.delete();
    ch8.delete(); ch8_c.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    clear_logs();
  endtask

  task automatic send16(input logic [15:0] w);
    int n;
    @(negedge clk);
    if16.word_i = w;
    if16.word_valid_i = 1'b1;
    n = 0;
    while (!if16.word_ready_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL send16 timeout: word_ready_o stayed 0, required 1");
    end
    @(negedge clk);
    if16.word_valid_i = 1'b0;
  endtask

  task automatic wait_idle16();
    int n = 0;
    @(negedge clk);
    while (if16.busy_o && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      tests_run++; tests_failed++;
      $display("FAIL wait_idle16 timeout: busy_o stayed 1, required 0");
    end
  endtask

  task automatic wait_chars16(input int cnt);
    int n = 0;
    while (ch16.size() < cnt && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL wait_chars16 timeout: got %0d chars, required %0d", ch16.size(), cnt);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (if16.word_ready_o !== 1'b0) begin tests_failed++; $display("FAIL rst_ready got %b want 0", if16.word_ready_o); end
    tests_run++;
    if (if16.xmit_o !== 1'b0) begin tests_failed++; $display("FAIL rst_xmit got %b want 0", if16.xmit_o); end
    tests_run++;
    if (if16.txchar_o !== 8'h20) begin tests_failed++; $display("FAIL rst_txchar got %h want 20", if16.txchar_o); end
    tests_run++;
    if (if16.busy_o !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %b want 0", if16.busy_o); end
    nreset = 1'b1;
    #1;
    tests_run++;
    if (if16.word_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready got %b want 1", if16.word_ready_o); end
    tests_run++;
    if (if8.word_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready8 got %b want 1", if8.word_ready_o); end
    clear_logs();
  endtask

  task automatic test_basic();
    int d;
    do_reset();
    send16(16'h12af);
    wait_idle16();
    d = str_diff(ch16, "12af ");
    tests_run++;
    if (d != -1) begin tests_failed++; $display("FAIL basic_chars got %s want 31 32 61 66 20", q2s(ch16)); end
    if (ch16.size() == 5 && acc16_c.size() == 1) begin
      tests_run++;
      if (ch16_c[0] != acc16_c[0] + 2) begin
        tests_failed++; $display("FAIL basic_latency got %0d want %0d", ch16_c[0] - acc16_c[0], 2);
      end
      tests_run++;
      if (ch16_c[4] - ch16_c[0] != 4) begin
        tests_failed++; $display("FAIL basic_consecutive got span %0d want 4", ch16_c[4] - ch16_c[0]);
      end
      tests_run++;
      if (ch16_b[4] !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_last got %b want 1", ch16_b[4]); end
    end
    tests_run++;
    if (if16.word_ready_o !== 1'b1) begin tests_failed++; $display("FAIL basic_ready_after got %b want 1", if16.word_ready_o); end
  endtask

  task automatic test_backpressure();
    int d;
    do_reset();
    send16(16'hbeef);
    wait_chars16(2);
    if16.tx_full_i = 1'b1;
    repeat (5) @(negedge clk);
    if16.tx_full_i = 1'b0;
    wait_idle16();
    d = str_diff(ch16, "beef ");
    tests_run++;
    if (d != -1) begin tests_failed++; $display("FAIL full_chars got %s want 62 65 65 66 20", q2s(ch16)); end
    if (ch16.size() == 5) begin
      tests_run++;
      if (ch16_c[2] - ch16_c[1] != 6) begin
        tests_failed++; $display("FAIL full_stall_gap got %0d want 6", ch16_c[2] - ch16_c[1]);
      end
      tests_run++;
      if (ch16_c[4] - ch16_c[2] != 2) begin
        tests_failed++; $display("FAIL full_resume_gap got %0d want 2", ch16_c[4] - ch16_c[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, d;
    string exp;
    do_reset();
    @(negedge clk);
    if16.word_i = 16'h0001;
    if16.word_valid_i = 1'b1;
    n = 0;
    while (acc16_w.size() < 1 && n < 50) begin @(negedge clk); n++; end
    if16.word_i = 16'h0002;
    while (acc16_w.size() < 2 && n < 100) begin @(negedge clk); n++; end
    if16.word_valid_i = 1'b0;
    wait_idle16();
    repeat (10) @(negedge clk);
    tests_run++;
    if (acc16_w.size() != 2) begin tests_failed++; $display("FAIL b2b_accept_count got %0d want 2", acc16_w.size()); end
    if (acc16_w.size() == 2) begin
      tests_run++;
      if (acc16_w[0] !== 16'h0001 || acc16_w[1] !== 16'h0002) begin
        tests_failed++; $display("FAIL b2b_words got %h %h want 0001 0002", acc16_w[0], acc16_w[1]);
      end
      tests_run++;
      if (acc16_c[1] - acc16_c[0] != 6) begin
        tests_failed++; $display("FAIL b2b_spacing got %0d want 6", acc16_c[1] - acc16_c[0]);
      end
    end
`ifdef HEX_STREAM_NEWLINE_EN
    exp = "0001 0002\015\012";
`else
    exp = "0001 0002 ";
`endif
    d = str_diff(ch16, exp);
    tests_run++;
    if (d != -1) begin tests_failed++; $display("FAIL b2b_chars got %s want \"%s\"", q2s(ch16), exp); end
  endtask

  task automatic test_reset_mid_word();
    int d;
    do_reset();
    send16(16'h1234);
    wait_chars16(2);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    #1;
    tests_run++;
    if (if16.busy_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got %b want 0", if16.busy_o); end
    tests_run++;
    if (if16.word_ready_o !== 1'b1) begin tests_failed++; $display("FAIL midrst_ready got %b want 1", if16.word_ready_o); end
    repeat (10) @(negedge clk);
    d = str_diff(ch16, "12");
    tests_run++;
    if (d != -1) begin tests_failed++; $display("FAIL midrst_chars got %s want 31 32", q2s(ch16)); end
  endtask

  task automatic test_width8();
    int n, d;
    do_reset();
    @(negedge clk);
    if8.word_i = 8'h9a;
    if8.word_valid_i = 1'b1;
    @(negedge clk);
    if8.word_valid_i = 1'b0;
    n = 0;
    while (if8.busy_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin tests_run++; tests_failed++; $display("FAIL w8_timeout busy_o stayed 1 want 0"); end
    repeat (3) @(negedge clk);
    d = str_diff(ch8, "9a ");
    tests_run++;
    if (d != -1) begin tests_failed++; $display("FAIL w8_chars got %s want 39 61 20", q2s(ch8)); end
    tests_run++;
    if (acc8_c.size() != 1) begin tests_failed++; $display("FAIL w8_accept_count got %0d want 1", acc8_c.size()); end
    if (acc8_c.size() == 1 && ch8.size() == 3) begin
      tests_run++;
      if (ch8_c[0] != acc8_c[0] + 2) begin
        tests_failed++; $display("FAIL w8_latency got %0d want 2", ch8_c[0] - acc8_c[0]);
      end
    end
  endtask

`ifdef HEX_STREAM_NEWLINE_EN
  task automatic test_newline();
    int d;
    do_reset();
    send16(16'h0000);
    send16(16'hffff);
    wait_idle16();
    d = str_diff(ch16, "0000 ffff\015\012");
    tests_run++;
    if (d != -1) begin tests_failed++; $display("FAIL nl_chars got %s want 30 30 30 30 20 66 66 66 66 0d 0a", q2s(ch16)); end
    tests_run++;
    if (dut16.line_q !== 8'd0) begin tests_failed++; $display("FAIL nl_line_cnt got %0d want 0", dut16.line_q); end
  endtask
`endif

  initial begin
    if16.word_i = '0; if16.word_valid_i = 1'b0; if16.tx_full_i = 1'b0;
    if8.word_i = '0;  if8.word_valid_i = 1'b0;  if8.tx_full_i = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_width8();
`ifdef HEX_STREAM_NEWLINE_EN
    test_newline();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
